// File: rtl/traffic_phase_arbiter_pkg.sv
// Shared encodings for the junction controllers: per-road signal aspects,
// controller phases and the boolean constants used by the signal controllers.
package traffic_phase_arbiter_pkg;

    typedef enum logic [1:0] {
        SIG_RED    = 2'd0,
        SIG_YELLOW = 2'd1,
        SIG_GREEN  = 2'd2
    } sig_e;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Owner index width; a two-road junction still needs one bit.
    function automatic int owner_width(input int n_roads);
        return (n_roads > 2) ? $clog2(n_roads) : 1;
    endfunction

endpackage

// File: rtl/traffic_phase_arbiter_if.sv
// Sensor/emergency inputs and signal-head outputs of the junction arbiter.
interface traffic_phase_arbiter_if
    import traffic_phase_arbiter_pkg::*;
#(
    parameter int N_ROADS = 4,
    parameter int OW_W    = owner_width(N_ROADS)
) ();

    logic [N_ROADS-1:0]   CAR_ON_RD;
    logic                 EMERG;
    logic [OW_W-1:0]      EMERG_ID;
    logic [2*N_ROADS-1:0] SIG;
    logic [OW_W-1:0]      OWNER;
    logic [1:0]           PHASE;

    modport master (
        output CAR_ON_RD, EMERG, EMERG_ID,
        input  SIG, OWNER, PHASE
    );

    modport slave (
        input  CAR_ON_RD, EMERG, EMERG_ID,
        output SIG, OWNER, PHASE
    );

endinterface

// File: rtl/traffic_phase_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_start,
// wrapping modulo N_ROADS.
module traffic_phase_arbiter_rr_pick
    import traffic_phase_arbiter_pkg::*;
#(
    parameter int N_ROADS = 4,
    parameter int OW_W    = owner_width(N_ROADS)
) (
    input  logic [N_ROADS-1:0] i_req,
    input  logic [OW_W-1:0]    i_start,
    output logic               o_found,
    output logic [OW_W-1:0]    o_index
);

    localparam logic [OW_W:0] N_EXT = (OW_W+1)'(N_ROADS);

    always_comb begin
        logic [OW_W:0] w_idx;
        o_found = FALSE;
        o_index = '0;
        w_idx   = '0;
        // Walk farthest-first so the closest hit to i_start is written last.
        for (int k = N_ROADS - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_start} + (OW_W+1)'(k);
            if (w_idx >= N_EXT) begin
                w_idx = w_idx - N_EXT;
            end
            if (i_req[w_idx[OW_W-1:0]]) begin
                o_found = TRUE;
                o_index = w_idx[OW_W-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Round-robin junction arbiter: one green approach at a time, bounded green,
// yellow and all-red clearance on every owner change, emergency preemption.
module traffic_phase_arbiter
    import traffic_phase_arbiter_pkg::*;
#(
    parameter int N_ROADS   = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int CNT_W     = 4
) (
    input  logic                    CLOCK,
    input  logic                    CLEAR,
    traffic_phase_arbiter_if.slave  bus
);

    localparam int OW_W = owner_width(N_ROADS);

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y2R_M1 = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] R2G_M1 = CNT_W'(R2G_DELAY - 1);
    localparam logic [OW_W-1:0]  LAST_ROAD = OW_W'(N_ROADS - 1);

    phase_e               r_phase;
    phase_e               w_phase_nxt;
    logic [OW_W-1:0]      r_owner;
    logic [OW_W-1:0]      r_next_owner;
    logic [CNT_W-1:0]     r_timer;
    logic [N_ROADS-1:0]   r_pending;

    logic [N_ROADS-1:0]   w_req_all;
    logic [N_ROADS-1:0]   w_owner_oh;
    logic [N_ROADS-1:0]   w_grant_oh;
    logic [OW_W-1:0]      w_start;
    logic [OW_W-1:0]      w_rr_index;
    logic [OW_W-1:0]      w_grant;
    logic                 w_other_pend;
    logic                 w_emerg_vld;
    logic                 w_emerg_other;
    logic                 w_emerg_hold;
    logic                 w_owner_car;
    logic                 w_normal_exit;
    logic                 w_green_exit;
    logic                 w_yel_done;
    logic                 w_red_done;
    logic                 w_enter_green;
    logic [2*N_ROADS-1:0] w_sig;

    // Request qualification
    assign w_req_all     = r_pending | bus.CAR_ON_RD;
    assign w_owner_oh    = N_ROADS'(1) << r_owner;
    assign w_start       = (r_owner == LAST_ROAD) ? '0 : r_owner + 1'b1;
    assign w_owner_car   = bus.CAR_ON_RD[r_owner];

    // An out-of-range emergency target is treated as no emergency at all.
    assign w_emerg_vld   = bus.EMERG && ({1'b0, bus.EMERG_ID} < (OW_W+1)'(N_ROADS));
    assign w_emerg_other = w_emerg_vld && (bus.EMERG_ID != r_owner);
    assign w_emerg_hold  = w_emerg_vld && (bus.EMERG_ID == r_owner);

    traffic_phase_arbiter_rr_pick #(
        .N_ROADS (N_ROADS),
        .OW_W    (OW_W)
    ) u_rr_pick (
        .i_req   (w_req_all & ~w_owner_oh),
        .i_start (w_start),
        .o_found (w_other_pend),
        .o_index (w_rr_index)
    );

    assign w_normal_exit = w_other_pend && (r_timer >= MIN_M1) &&
                           (!w_owner_car || (r_timer >= MAX_M1));
    // An emergency for the current owner pins green even past MAX_GREEN.
    assign w_green_exit  = !w_emerg_hold && (w_emerg_other || w_normal_exit);
    assign w_yel_done    = (r_timer == Y2R_M1);
    assign w_red_done    = (r_timer == R2G_M1);
    assign w_enter_green = (r_phase == PH_ALLRED) && w_red_done;

    // A late emergency in the final all-red cycle still picks the new owner.
    assign w_grant       = w_emerg_vld ? bus.EMERG_ID : r_next_owner;
    assign w_grant_oh    = N_ROADS'(1) << w_grant;

    // Phase state register
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            r_phase <= PH_GREEN;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next-phase logic
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_GREEN:  if (w_green_exit) w_phase_nxt = PH_YELLOW;
            PH_YELLOW: if (w_yel_done)   w_phase_nxt = PH_ALLRED;
            PH_ALLRED: if (w_red_done)   w_phase_nxt = PH_GREEN;
            default:                     w_phase_nxt = PH_GREEN;
        endcase
    end

    // Timer, ownership and sticky request bookkeeping
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            r_timer      <= '0;
            r_owner      <= '0;
            r_next_owner <= '0;
            r_pending    <= '0;
        end else begin
            if (w_phase_nxt != r_phase) begin
                r_timer <= '0;
            end else if (r_phase == PH_GREEN) begin
                if (r_timer < MAX_M1) begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (r_phase == PH_GREEN) begin
                if (w_green_exit) begin
                    r_next_owner <= w_emerg_other ? bus.EMERG_ID : w_rr_index;
                end
            end else if (w_emerg_vld) begin
                r_next_owner <= bus.EMERG_ID;
            end

            if (w_enter_green) begin
                r_owner <= w_grant;
            end

            // Clearing the road being granted wins over its sensor this cycle.
            r_pending <= w_req_all & ~(w_enter_green ? w_grant_oh : '0);
        end
    end

    // Output decode from state registers only
    always_comb begin
        w_sig = '0;
        for (int i = 0; i < N_ROADS; i++) begin
            w_sig[2*i +: 2] = SIG_RED;
            if (r_owner == OW_W'(i)) begin
                if (r_phase == PH_GREEN) begin
                    w_sig[2*i +: 2] = SIG_GREEN;
                end else if (r_phase == PH_YELLOW) begin
                    w_sig[2*i +: 2] = SIG_YELLOW;
                end
            end
        end
    end

    assign bus.SIG   = w_sig;
    assign bus.OWNER = r_owner;
    assign bus.PHASE = r_phase;

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
- Multi-approach intersection controller that shares a single junction among N_ROADS roads.
- Each road has a car sensor. The block grants green to one road at a time, round-robin among pending requests.
- Green time is bounded by minimum and maximum limits. Every change of owner passes through yellow and all-red clearance.
- Emergency preemption is supported. Sits where the two-road signal controller sits today, for junctions with more than two approaches.

Parameters:
- N_ROADS, 4, number of approaches (2..8); owner index width OW_W = clog2(N_ROADS).
- MIN_GREEN, 4, minimum green cycles before the owner may be preempted by a normal request.
- MAX_GREEN, 12, maximum green cycles while other roads are pending.
- Y2R_DELAY, 3, yellow cycles.
- R2G_DELAY, 2, all-red clearance cycles.
- CNT_W, 4, phase timer width; must hold MAX_GREEN-1.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- CLEAR  in  1  asynchronous, active-low reset.
- CAR_ON_RD  in  N_ROADS  level car-present sensor, one bit per road.
- EMERG  in  1  emergency preemption request, level.
- EMERG_ID  in  OW_W  road to be served by the emergency request.
- SIG  out  2*N_ROADS  per-road signal; road i occupies SIG[2i+1:2i]; encoding RED=0, YELLOW=1, GREEN=2.
- OWNER  out  OW_W  road currently owning the junction.
- PHASE  out  2  current state: GREEN=0, YELLOW=1, ALLRED=2.

Behaviour:
- All outputs are registered and are decoded from the state, OWNER and timer registers only.
- Reset (CLEAR=0, asynchronous):
  - PHASE=GREEN, OWNER=0, timer=0, pending=0, next_owner=0.
  - SIG has road 0 GREEN and all other roads RED.
  - This holds immediately on assertion, including mid-yellow or mid-all-red.
- pending[i]: sticky request bit.
  - Set on any cycle CAR_ON_RD[i]=1, so a 1-cycle car pulse is served.
  - Cleared on the cycle road i enters GREEN; clear wins over a simultaneous set for that road.
- GREEN state:
  - Owner's SIG=GREEN; all other roads RED.
  - timer increments each cycle, saturating at MAX_GREEN-1.
  - other_pend = any pending[j] or CAR_ON_RD[j] with j != OWNER.
  - Normal exit condition: other_pend and timer >= MIN_GREEN-1 and (CAR_ON_RD[OWNER]=0 or timer >= MAX_GREEN-1). On exit go to YELLOW next cycle.
  - At exit, latch next_owner = first road with pending|CAR_ON_RD, searching OWNER+1, OWNER+2, ... with wrap modulo N_ROADS, excluding OWNER.
  - No other requests: stay GREEN on the current owner indefinitely (park).
- Emergency:
  - EMERG=1 with EMERG_ID != OWNER in GREEN: exit to YELLOW next cycle regardless of MIN_GREEN; next_owner=EMERG_ID.
  - EMERG=1 with EMERG_ID == OWNER: hold GREEN; do not exit, even past MAX_GREEN.
  - EMERG arriving during YELLOW or ALLRED overrides next_owner with EMERG_ID; the phase timing is unchanged.
- YELLOW state:
  - Owner's SIG=YELLOW; others RED.
  - Lasts exactly Y2R_DELAY cycles (timer reset to 0 on entry), then ALLRED.
- ALLRED state:
  - All roads RED.
  - Lasts exactly R2G_DELAY cycles, then GREEN with OWNER=next_owner, timer=0, and pending[next_owner] cleared.
- Invariants:
  - Never two roads non-RED simultaneously.
  - A GREEN to GREEN change of owner always includes >= Y2R_DELAY+R2G_DELAY intervening cycles.
- EMERG_ID >= N_ROADS is ignored (treated as EMERG=0).

Decomposition:
- Shared include/package holds:
  - signal encodings RED/YELLOW/GREEN;
  - phase encodings GREEN/YELLOW/ALLRED;
  - TRUE/FALSE constants, shared with the existing signal controller.
- One sub-module: rr_pick. It is purely combinational, with inputs req[N_ROADS] and start index, and outputs found and index. It is instantiated once for next_owner selection and is unit-testable on its own.

Test Plan:
- Reset: hold CLEAR=0 for 3 cycles, release, no cars -> SIG=8'b00_00_00_10, OWNER=0, PHASE=GREEN, stable for 50 cycles.
- Single 1-cycle pulse on CAR_ON_RD[2] at cycle 10 after reset, road 0 idle -> PHASE=YELLOW at cycle 11 for 3 cycles, ALLRED for 2 cycles, then OWNER=2 and SIG=8'b00_10_00_00.
- CAR_ON_RD[0] and CAR_ON_RD[1] both held from reset -> road 0 GREEN for exactly 12 cycles, then yellow; road 1 GREEN 5 cycles later.
- OWNER=1 in GREEN, pending on roads 0 and 3, road 1 car drops after MIN_GREEN -> next owner 3 (wrap order 2,3,0), then 0 after road 3's service.
- EMERG=1, EMERG_ID=3 at green timer=1 on road 0 with no cars -> YELLOW next cycle (MIN_GREEN bypassed); OWNER=3 GREEN after 3+2 cycles, held while EMERG stays 1 beyond 12 cycles even with CAR_ON_RD[1]=1.
- Assert CLEAR=0 mid-YELLOW, asynchronous to CLOCK -> SIG goes to 8'b00_00_00_10 without waiting for an edge; pending cleared; normal operation resumes after release.
